// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial bit-pattern detector with match counter
//
// Purpose: watches a one-bit serial stream and emits a registered one-cycle
// pulse each time the last LEN accepted bits equal PATTERN (MSB = oldest bit).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   clr          in   synchronous clear of history/fill/counter/out, beats en
//   en           in   data qualifier, data_in accepted only when high
//   data_in      in   serial input bit
//   out          out  registered match pulse
//   match_count  out  saturating number of matches since reset/clr
//   fill         out  number of valid bits held toward a match (0..LEN)
module seq_detector_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            FW      = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             data_in,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic [FW-1:0]    fill
);

    logic [LEN-1:0] history;
    logic [LEN-1:0] hist_next;
    logic [FW-1:0]  fill_inc;
    logic           hit;

    always_comb begin
        hist_next = {history[LEN-2:0], data_in};
        // The fill guard keeps the all-zero reset history from matching
        // patterns such as all zeros before LEN real bits have arrived.
        hit       = (hist_next == PATTERN) && (fill >= FW'(LEN - 1));
        fill_inc  = (fill == FW'(LEN)) ? fill : fill + FW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history     <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
        end else if (clr) begin
            history     <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
        end else if (en) begin
            history <= hist_next;
            out     <= hit;
            if (hit) begin
                if (!(&match_count)) begin
                    match_count <= match_count + CNT_W'(1);
                end
                // Non-overlapping mode demands a completely fresh window.
                fill <= OVERLAP ? FW'(LEN) : '0;
            end else begin
                fill <= fill_inc;
            end
        end else begin
            // Bubble: history and progress are kept, only the pulse drops.
            out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - vector table and scoreboard bench for seq_detector_param
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       data_in = 1'b0;
    logic [3:0] en_v = 4'b0;
    logic [1:0] sel = 2'd0;

    logic       out_a, out_b, out_c, out_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;
    logic [2:0] fill_a, fill_b, fill_d;
    logic [1:0] fill_c;

    int act_out, act_cnt, act_fill;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // A: defaults, B: no overlap, C: LEN=3 all-zero pattern, D: 1111 with 2-bit counter
    seq_detector_param u_a (
        .clk(clk), .reset(reset), .clr(clr), .en(en_v[0]), .data_in(data_in),
        .out(out_a), .match_count(cnt_a), .fill(fill_a)
    );
    seq_detector_param #(.OVERLAP(1'b0)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .en(en_v[1]), .data_in(data_in),
        .out(out_b), .match_count(cnt_b), .fill(fill_b)
    );
    seq_detector_param #(.LEN(3), .PATTERN(3'b000)) u_c (
        .clk(clk), .reset(reset), .clr(clr), .en(en_v[2]), .data_in(data_in),
        .out(out_c), .match_count(cnt_c), .fill(fill_c)
    );
    seq_detector_param #(.PATTERN(4'b1111), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .clr(clr), .en(en_v[3]), .data_in(data_in),
        .out(out_d), .match_count(cnt_d), .fill(fill_d)
    );

    always_comb begin
        act_out  = 0;
        act_cnt  = 0;
        act_fill = 0;
        case (sel)
            2'd0: begin act_out = int'(out_a); act_cnt = int'(cnt_a); act_fill = int'(fill_a); end
            2'd1: begin act_out = int'(out_b); act_cnt = int'(cnt_b); act_fill = int'(fill_b); end
            2'd2: begin act_out = int'(out_c); act_cnt = int'(cnt_c); act_fill = int'(fill_c); end
            default: begin act_out = int'(out_d); act_cnt = int'(cnt_d); act_fill = int'(fill_d); end
        endcase
    end

    typedef struct {
        string    name;
        bit       rst_first;
        bit [1:0] sel;
        bit       clr;
        bit       en;
        bit       din;
        int       eo;
        int       ec;
        int       ef;
    } vec_t;

    typedef struct {
        string name;
        int    eo;
        int    ec;
        int    ef;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input bit rf, input bit [1:0] s,
                                input bit c, input bit e, input bit d,
                                input int eo, input int ec, input int ef);
        vec_t v;
        v.name = nm; v.rst_first = rf; v.sel = s; v.clr = c; v.en = e; v.din = d;
        v.eo = eo; v.ec = ec; v.ef = ef;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        clr   = 1'b0;
        en_v  = 4'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        if (v.rst_first) do_reset();
        sel     = v.sel;
        clr     = v.clr;
        data_in = v.din;
        en_v    = v.en ? (4'b0001 << v.sel) : 4'b0000;
        e.name = v.name; e.eo = v.eo; e.ec = v.ec; e.ef = v.ef;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.name, ".out"}, act_out, e.eo);
        check({e.name, ".count"}, act_cnt, e.ec);
        check({e.name, ".fill"}, act_fill, e.ef);
        clr  = 1'b0;
        en_v = 4'b0;
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        vecs.delete();
    endtask

    task automatic async_reset_check(input string nm);
        #2;
        reset = 1'b1;
        #1;
        check({nm, ".out"}, act_out, 0);
        check({nm, ".count"}, act_cnt, 0);
        check({nm, ".fill"}, act_fill, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check("reset.out", act_out, 0);
            check("reset.count", act_cnt, 0);
            check("reset.fill", act_fill, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // overlap: 1,0,1,1,0,1,1
        add("ovl", 1, 0, 0, 1, 1, 0, 0, 1);
        add("ovl", 0, 0, 0, 1, 0, 0, 0, 2);
        add("ovl", 0, 0, 0, 1, 1, 0, 0, 3);
        add("ovl", 0, 0, 0, 1, 1, 1, 1, 4);
        add("ovl", 0, 0, 0, 1, 0, 0, 1, 4);
        add("ovl", 0, 0, 0, 1, 1, 0, 1, 4);
        add("ovl", 0, 0, 0, 1, 1, 1, 2, 4);
        // no overlap: same stream
        add("novl", 1, 1, 0, 1, 1, 0, 0, 1);
        add("novl", 0, 1, 0, 1, 0, 0, 0, 2);
        add("novl", 0, 1, 0, 1, 1, 0, 0, 3);
        add("novl", 0, 1, 0, 1, 1, 1, 1, 0);
        add("novl", 0, 1, 0, 1, 0, 0, 1, 1);
        add("novl", 0, 1, 0, 1, 1, 0, 1, 2);
        add("novl", 0, 1, 0, 1, 1, 0, 1, 3);
        // all-zero pattern, fill guard
        add("zero", 1, 2, 0, 1, 0, 0, 0, 1);
        add("zero", 0, 2, 0, 1, 0, 0, 0, 2);
        add("zero", 0, 2, 0, 1, 0, 1, 1, 3);
        add("zero", 0, 2, 0, 1, 0, 1, 2, 3);
        add("zero", 0, 2, 0, 1, 0, 1, 3, 3);
        // saturation: ten ones, then a bubble, then one more
        add("sat", 1, 3, 0, 1, 1, 0, 0, 1);
        add("sat", 0, 3, 0, 1, 1, 0, 0, 2);
        add("sat", 0, 3, 0, 1, 1, 0, 0, 3);
        add("sat", 0, 3, 0, 1, 1, 1, 1, 4);
        add("sat", 0, 3, 0, 1, 1, 1, 2, 4);
        add("sat", 0, 3, 0, 1, 1, 1, 3, 4);
        for (int k = 0; k < 4; k++) add("sat", 0, 3, 0, 1, 1, 1, 3, 4);
        add("sat_gap", 0, 3, 0, 0, 1, 0, 3, 4);
        add("sat", 0, 3, 0, 1, 1, 1, 3, 4);
        // bubble: 1,0, three disabled ones, 1,1
        add("bub", 1, 0, 0, 1, 1, 0, 0, 1);
        add("bub", 0, 0, 0, 1, 0, 0, 0, 2);
        for (int k = 0; k < 3; k++) add("bub_gap", 0, 0, 0, 0, 1, 0, 0, 2);
        add("bub", 0, 0, 0, 1, 1, 0, 0, 3);
        add("bub", 0, 0, 0, 1, 1, 1, 1, 4);
        // clr on the fourth edge, then clr after a counted match
        add("clr", 1, 0, 0, 1, 1, 0, 0, 1);
        add("clr", 0, 0, 0, 1, 0, 0, 0, 2);
        add("clr", 0, 0, 0, 1, 1, 0, 0, 3);
        add("clr_edge", 0, 0, 1, 1, 1, 0, 0, 0);
        add("clr_after", 0, 0, 0, 1, 1, 0, 0, 1);
        add("clr2", 1, 0, 0, 1, 1, 0, 0, 1);
        add("clr2", 0, 0, 0, 1, 0, 0, 0, 2);
        add("clr2", 0, 0, 0, 1, 1, 0, 0, 3);
        add("clr2", 0, 0, 0, 1, 1, 1, 1, 4);
        add("clr2_edge", 0, 0, 1, 0, 0, 0, 0, 0);
        add("clr2_after", 0, 0, 0, 1, 0, 0, 0, 1);
        add("clr2_after", 0, 0, 0, 1, 1, 0, 0, 2);
        add("clr2_after", 0, 0, 0, 1, 1, 0, 0, 3);
        run_vecs();

        // async reset while out is high after a match
        add("ar", 1, 0, 0, 1, 1, 0, 0, 1);
        add("ar", 0, 0, 0, 1, 0, 0, 0, 2);
        add("ar", 0, 0, 0, 1, 1, 0, 0, 3);
        add("ar", 0, 0, 0, 1, 1, 1, 1, 4);
        run_vecs();
        async_reset_check("ar_mid");

        // pattern straddling an async reset is not detected
        add("ar2", 0, 0, 0, 1, 1, 0, 0, 1);
        add("ar2", 0, 0, 0, 1, 0, 0, 0, 2);
        add("ar2", 0, 0, 0, 1, 1, 0, 0, 3);
        run_vecs();
        async_reset_check("ar2_mid");
        add("ar2_after", 0, 0, 0, 1, 1, 0, 0, 1);
        run_vecs();

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
